// File: rtl/spi_master.sv
// Master end of the 11-cycle SPI command protocol: serialises a 10-bit command
// on MOSI and, for read-data frames, collects an 8-bit MISO response.
module spi_master #(
    parameter int unsigned RD_WAIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] cmd,
    output logic       ready,
    output logic       done,
    output logic       cmd_err,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    localparam logic [1:0] T_RD_ADDR = 2'b10;
    localparam logic [1:0] T_RD_DATA = 2'b11;
    // WAIT hands over to READ one edge before the first MISO sample edge.
    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 2);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  sh_q, sh_d;
    logic [1:0]  typ_q, typ_d;
    logic [7:0]  rx_q, rx_d;
    logic        flag_q, flag_d;
    logic        ss_q, ss_d;
    logic        mosi_q, mosi_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        rv_q, rv_d;
    logic [7:0]  rd_q, rd_d;
    logic        reject;

    assign reject = ((cmd[9:8] == T_RD_DATA) && !flag_q) ||
                    ((cmd[9:8] == T_RD_ADDR) && flag_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        typ_d   = typ_q;
        rx_d    = rx_q;
        flag_d  = flag_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rv_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ss_d   = 1'b1;
                mosi_d = 1'b0;
                if (start) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        sh_d    = cmd;
                        typ_d   = cmd[9:8];
                        cnt_d   = 4'd0;
                        ss_d    = 1'b0;
                        mosi_d  = cmd[9];
                    end
                end
            end
            S_SETUP: begin
                mosi_d = sh_q[9];
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_SHIFT;
                    cnt_d   = 4'd0;
                end
            end
            S_SHIFT: begin
                if (cnt_q == 4'd9) begin
                    mosi_d = 1'b0;
                    cnt_d  = 4'd0;
                    if (typ_q == T_RD_DATA) begin
                        state_d = (RD_WAIT == 1) ? S_READ : S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                        ss_d    = 1'b1;
                        done_d  = 1'b1;
                        if (typ_q == T_RD_ADDR) flag_d = 1'b1;
                    end
                end else begin
                    mosi_d = sh_q[8];
                    sh_d   = {sh_q[8:0], 1'b0};
                    cnt_d  = cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_READ;
                    cnt_d   = 4'd0;
                end
            end
            S_READ: begin
                rx_d  = {rx_q[6:0], MISO};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    rd_d    = {rx_q[6:0], MISO};
                    rv_d    = 1'b1;
                    done_d  = 1'b1;
                    ss_d    = 1'b1;
                    flag_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ss_d    = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sh_q    <= 10'd0;
            typ_q   <= 2'd0;
            rx_q    <= 8'd0;
            flag_q  <= 1'b0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
            rd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            typ_q   <= typ_d;
            rx_q    <= rx_d;
            flag_q  <= flag_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign cmd_err  = err_q;
    assign rd_data  = rd_q;
    assign rd_valid = rv_q;
    assign SS_n     = ss_q;
    assign MOSI     = mosi_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a frame-timing model plus a small slave/RAM model,
// compared against the DUT every cycle, with directed command vectors.
module tb_spi_master;

    localparam int RD_WAIT = 3;

    logic       clk, rst_n, start, MISO;
    logic [9:0] cmd;
    logic       ready, done, cmd_err, rd_valid, SS_n, MOSI;
    logic [7:0] rd_data;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    spi_master #(.RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
        .ready(ready), .done(done), .cmd_err(cmd_err), .rd_data(rd_data),
        .rd_valid(rd_valid), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .state_o(state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- model: frame timing + slave/RAM ----------------
    logic [7:0] mem [256];
    logic [7:0] m_waddr, m_raddr, m_rd;
    logic [9:0] m_cmd;
    logic       m_busy, m_flag, m_ss, m_mosi, m_done, m_rv, m_err, m_ready;
    int         m_n;

    function automatic int frame_len(input logic [9:0] c);
        return (c[9:8] == 2'b11) ? 19 + RD_WAIT : 12;
    endfunction

    // {SS_n, MOSI, done, rd_valid} registered at edge E(n) of a frame for command c
    function automatic logic [3:0] frame_out(input logic [9:0] c, input int n);
        if (n == frame_len(c)) return {1'b1, 1'b0, 1'b1, (c[9:8] == 2'b11)};
        if (n <= 2)            return {1'b0, c[9], 2'b00};
        if (n <= 11)           return {1'b0, c[11-n], 2'b00};
        return 4'b0000;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h5A] = 8'hC3;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_n <= 0; m_flag <= 1'b0; m_cmd <= '0;
            m_ss <= 1'b1; m_mosi <= 1'b0; m_done <= 1'b0; m_rv <= 1'b0;
            m_err <= 1'b0; m_ready <= 1'b1; m_rd <= 8'h00;
        end else if (m_busy) begin
            m_n <= m_n + 1;
            m_err <= 1'b0;
            {m_ss, m_mosi, m_done, m_rv} <= frame_out(m_cmd, m_n + 1);
            if (m_n + 1 == frame_len(m_cmd)) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                case (m_cmd[9:8])
                    2'b00: m_waddr <= m_cmd[7:0];
                    2'b01: mem[m_waddr] <= m_cmd[7:0];
                    2'b10: begin m_raddr <= m_cmd[7:0]; m_flag <= 1'b1; end
                    default: begin m_rd <= mem[m_raddr]; m_flag <= 1'b0; end
                endcase
            end
        end else begin
            m_done <= 1'b0; m_rv <= 1'b0; m_ss <= 1'b1; m_mosi <= 1'b0;
            m_err  <= 1'b0;
            if (start) begin
                if ((cmd[9:8] == 2'b11 && !m_flag) || (cmd[9:8] == 2'b10 && m_flag)) begin
                    m_err <= 1'b1;
                end else begin
                    m_busy <= 1'b1; m_n <= 0; m_cmd <= cmd; m_ready <= 1'b0;
                    {m_ss, m_mosi, m_done, m_rv} <= frame_out(cmd, 0);
                end
            end
        end
    end

    // Slave response: bit 7-j must be on MISO for edge E(12+RD_WAIT+j); noise otherwise.
    initial begin
        MISO = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (m_busy && m_cmd[9:8] == 2'b11 && m_n >= 11 + RD_WAIT && m_n <= 18 + RD_WAIT)
                MISO = mem[m_raddr][7 - (m_n - 11 - RD_WAIT)];
            else
                MISO = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en)
            check("outputs{ready,done,err,rv,ss,mosi,rd}",
                  {18'd0, ready, done, cmd_err, rd_valid, SS_n, MOSI, rd_data},
                  {18'd0, m_ready, m_done, m_err, m_rv, m_ss, m_mosi, m_rd});
    end

    // ---------------- driver tasks ----------------
    task automatic run_cmd(input logic [9:0] c, output int lat, output logic [11:0] bits);
        start = 1'b1; cmd = c;
        @(posedge clk); #1 start = 1'b0;
        lat = -1; bits = '0;
        for (int k = 0; k < 60 && lat < 0; k++) begin
            @(negedge clk);
            if (k < 12) bits = {bits[10:0], MOSI};
            if (done) lat = k;
        end
        if (lat < 0) check("frame_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic reject_cmd(input logic [9:0] c);
        start = 1'b1; cmd = c;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("rej_cmd_err", {31'd0, cmd_err}, 32'd1);
        check("rej_ss_n", {31'd0, SS_n}, 32'd1);
        check("rej_ready", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        logic [11:0] bits;
        rst_n = 1'b0; start = 1'b0; cmd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_ss_n", {31'd0, SS_n}, 32'd1);
        check("rst_mosi", {31'd0, MOSI}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);

        reject_cmd(10'h300);

        run_cmd(10'h0A5, lat, bits);
        check("wa_mosi_seq", {20'd0, bits}, 32'h0A5);
        check("wa_latency", lat, 32'd12);

        run_cmd(10'h13C, lat, bits);
        check("wd_latency", lat, 32'd12);

        run_cmd(10'h25A, lat, bits);
        check("ra_latency", lat, 32'd12);
        reject_cmd(10'h2FF);
        run_cmd(10'h300, lat, bits);
        check("rd_latency", lat, 32'd22);
        check("rd_data_5a", {24'd0, rd_data}, 32'hC3);

        run_cmd(10'h2A5, lat, bits);
        run_cmd(10'h300, lat, bits);
        check("rd_data_a5", {24'd0, rd_data}, 32'h3C);

        run_cmd(10'h25A, lat, bits);
        run_cmd(10'h001, lat, bits);
        check("write_while_pending", lat, 32'd12);
        run_cmd(10'h300, lat, bits);
        check("rd_data_5a_again", {24'd0, rd_data}, 32'hC3);

        // Busy start at E5 is dropped; reset lands just after E7.
        start = 1'b1; cmd = 10'h25A;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; cmd = 10'h011;
        @(posedge clk); #1 start = 1'b0;
        check("busy_ready", {31'd0, ready}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ss_n", {31'd0, SS_n}, 32'd1);
        check("mid_rst_mosi", {31'd0, MOSI}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk); @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        reject_cmd(10'h300);
        run_cmd(10'h0A5, lat, bits);
        check("post_rst_mosi_seq", {20'd0, bits}, 32'h0A5);
        check("post_rst_latency", lat, 32'd12);

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
